cpu_bus_arbiter: RTL
====================

# cpu_bus_arbiter

- Shares the single CPU-side memory port between three requesters:
  - the instruction fetcher (opcode/operand/pointer reads);
  - the execute unit (operand loads and stores);
  - the OAM DMA engine ($4014 transfers).
- Sits between those requesters and the memory map decoder.
- Issues one grant per phi1 cycle, inserts the 6502 DMA alignment halt cycles, and stops the fetcher from being starved by back-to-back execute traffic.

## Interface

Parameters:
- ADDR_WIDTH, 16, memory address width
- REG_WIDTH, 8, data width
- STARVE_LIMIT, 4, consecutive denied fetcher cycles before the fetcher is forced to win over execute
- DMA_LEN, 256, bytes per OAM DMA burst

Ports:
- phi1  in  1  clock; all state updates on posedge
- reset_n  in  1  reset, synchronous, active-low
- fet_req / exe_req / dma_req  in  1 each  access request; held high until granted
- fet_addr / exe_addr / dma_addr  in  ADDR_WIDTH each  request address
- exe_wdata / dma_wdata  in  REG_WIDTH each  write data
- exe_we / dma_we  in  1 each  write enable; the fetcher only reads
- fet_gnt / exe_gnt / dma_gnt  out  1 each  one-hot grant for the current cycle
- mem_addr  out  ADDR_WIDTH  muxed address
- mem_wdata  out  REG_WIDTH  muxed write data
- mem_we  out  1  muxed write enable
- cpu_halt  out  1  high while DMA owns or is aligning the bus
- rd_valid  out  3  one-hot per requester [fet, exe, dma]; high the cycle after a granted read

## Operation

- **States:** IDLE, CPU, DMA_ALIGN, DMA_RUN. The state and the owner are registered.
- **Reset:** state=IDLE, all gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_halt=0, rd_valid=0, starve_cnt=0, dma_cnt=0, parity=0.
- **Parity:**
  - Toggles every cycle after reset.
  - parity=1 marks an odd cycle.
- **CPU state arbitration, fixed priority dma > exe > fet, with one exception:**
  - If starve_cnt==STARVE_LIMIT and fet_req=1, the fetcher wins over execute.
- **starve_cnt:**
  - Increments when fet_req=1 and fet_gnt=0.
  - Clears when fet_gnt=1 or fet_req=0.
  - Saturates at STARVE_LIMIT.
- **DMA entry:**
  - A dma_req sampled in IDLE or CPU moves the state to DMA_ALIGN.
  - cpu_halt rises the same cycle.
- **DMA_ALIGN:**
  - One dummy cycle, plus one extra if the entry cycle was odd.
  - No grants during DMA_ALIGN.
- **DMA_RUN:**
  - dma_gnt=1 every cycle that dma_req=1.
  - dma_cnt counts granted writes.
  - Exit to IDLE after DMA_LEN writes; cpu_halt falls on that exit.
- **DMA pause:** dma_req dropping mid-run holds DMA_RUN with no grant. The CPU stays halted.
- **Bus muxing:**
  - mem_addr, mem_wdata and mem_we are driven from the granted requester.
  - With no grant: mem_we=0 and mem_addr holds its last value.
- **Read valid:** rd_valid[i] is a registered copy of (gnt[i] & ~we_i).

## Timing

- Grant latency is one cycle:
  - A request sampled at edge N yields gnt and the mem_* signals valid after edge N, for one cycle.
  - Requesters drop or advance req on seeing gnt.
- Read data is valid on the cycle rd_valid is high, which is edge N+1.
- Simultaneous fet_req+exe_req with starve_cnt<STARVE_LIMIT: exe is granted and starve_cnt increments.
- A request held with no change re-arbitrates every cycle; there is no bus lock for the CPU requesters.
- dma_req arriving in the same cycle as an exe write:
  - The exe write already granted for that cycle completes.
  - DMA_ALIGN starts the next cycle.
- reset_n low mid-DMA aborts the burst. All outputs take reset values at the next edge.
- dma_cnt wrap: the counter is $clog2(DMA_LEN)+1 bits wide, so DMA_LEN is reachable without overflow.

## Structure

- Shared package holds:
  - the state encoding (ARB_IDLE, ARB_CPU, ARB_DMA_ALIGN, ARB_DMA_RUN);
  - requester index constants REQ_FET=0, REQ_EXE=1, REQ_DMA=2.
- One sub-module, arb_starve_counter: saturating counter with inc/clr/sat outputs, parameterised by LIMIT.
- Everything else is a single always block for state and registers, plus combinational muxing.

## Test plan

- **Reset then single fetch:** reset_n=0 for 2 cycles, then fet_req=1, fet_addr=16'h8000 → fet_gnt=1 and mem_addr=16'h8000 the next cycle; rd_valid=3'b001 one cycle later.
- **Contention:** fet_req and exe_req both held with STARVE_LIMIT=4 → exe granted 4 cycles, fet granted on the 5th, then the pattern repeats.
- **Execute store:** exe_req=1, exe_we=1, exe_addr=16'h0200, exe_wdata=8'h5A → mem_we=1 and mem_wdata=8'h5A for one cycle; rd_valid stays 0.
- **DMA, even vs odd entry:**
  - dma_req on an even cycle → 1 align cycle, then 256 consecutive dma_gnt.
  - dma_req on an odd cycle → 2 align cycles.
  - In both cases cpu_halt is high throughout, and fet_gnt/exe_gnt stay 0.
- **DMA pause:** drop dma_req for 3 cycles mid-burst → no grants during the gap, the burst resumes at the same dma_cnt, and the total is still 256 writes.
- **Reset mid-DMA:** reset_n=0 at write 100 → the next cycle has state IDLE, cpu_halt=0, all gnt=0, dma_cnt=0.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// rtl/cpu_bus_arbiter_pkg.sv - shared state encoding and requester indices for the CPU bus arbiter
//
// Contents:
//   arb_state_t        arbiter FSM state encoding
//   REQ_FET/EXE/DMA    bit positions of each requester in grant and read-valid vectors
package cpu_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_CPU       = 2'd1,
        ARB_DMA_ALIGN = 2'd2,
        ARB_DMA_RUN   = 2'd3
    } arb_state_t;

    localparam int REQ_FET = 0;
    localparam int REQ_EXE = 1;
    localparam int REQ_DMA = 2;
    localparam int NUM_REQ = 3;

endpackage

// File: rtl/cpu_bus_arbiter_starve_counter.sv
// rtl/cpu_bus_arbiter_starve_counter.sv - saturating count of consecutive denied fetcher cycles
//
// Ports:
//   phi1     in   clock
//   reset_n  in   synchronous active-low reset
//   inc      in   fetcher requested and was denied this cycle
//   clr      in   fetcher was granted or stopped requesting (wins over inc)
//   sat      out  counter has reached LIMIT
module arb_starve_counter #(
    parameter  int LIMIT = 4,
    localparam int CW    = $clog2(LIMIT + 1)
) (
    input  logic phi1,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] cnt;

    assign sat = (cnt == CW'(LIMIT));

    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - single-port CPU bus arbiter for fetcher, execute unit and OAM DMA
//
// Ports:
//   phi1, reset_n                      clock, synchronous active-low reset
//   fet_req/exe_req/dma_req            access requests, held until granted
//   fet_addr/exe_addr/dma_addr         request addresses
//   exe_wdata/dma_wdata, exe_we/dma_we write data and enables (fetcher only reads)
//   fet_gnt/exe_gnt/dma_gnt            registered one-hot grant for the current cycle
//   mem_addr/mem_wdata/mem_we          registered muxed bus toward the memory map decoder
//   cpu_halt                           high while DMA is aligning or owns the bus
//   rd_valid                           [dma,exe,fet] read data valid, cycle after a read grant
module cpu_bus_arbiter
    import cpu_bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int REG_WIDTH    = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int DMA_LEN      = 256
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  fet_req,
    input  logic                  exe_req,
    input  logic                  dma_req,
    input  logic [ADDR_WIDTH-1:0] fet_addr,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [REG_WIDTH-1:0]  exe_wdata,
    input  logic [REG_WIDTH-1:0]  dma_wdata,
    input  logic                  exe_we,
    input  logic                  dma_we,
    output logic                  fet_gnt,
    output logic                  exe_gnt,
    output logic                  dma_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_halt,
    output logic [2:0]            rd_valid
);

    localparam int CNT_W = $clog2(DMA_LEN) + 1;

    arb_state_t         state;
    logic [NUM_REQ-1:0] gnt;
    logic [CNT_W-1:0]   dma_cnt;
    logic               parity;
    logic               align_left;
    logic               starve_sat;

    logic cpu_arb;
    logic fet_win;
    logic exe_win;
    logic dma_win;

    assign fet_gnt = gnt[REQ_FET];
    assign exe_gnt = gnt[REQ_EXE];
    assign dma_gnt = gnt[REQ_DMA];

    // CPU requesters only compete when no DMA is pending; a dma_req seen here
    // takes the bus away starting with the alignment cycles.
    assign cpu_arb = ((state == ARB_IDLE) || (state == ARB_CPU)) && !dma_req;
    assign fet_win = cpu_arb && fet_req && (!exe_req || starve_sat);
    assign exe_win = cpu_arb && exe_req && !fet_win;

    // The last alignment cycle already behaves as a run cycle, so the first
    // DMA grant follows the dummy cycle(s) directly.
    assign dma_win = dma_req && (dma_cnt != CNT_W'(DMA_LEN)) &&
                     ((state == ARB_DMA_RUN) || ((state == ARB_DMA_ALIGN) && !align_left));

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .phi1    (phi1),
        .reset_n (reset_n),
        .inc     (fet_req && !fet_win),
        .clr     (fet_win || !fet_req),
        .sat     (starve_sat)
    );

    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            cpu_halt   <= 1'b0;
            rd_valid   <= '0;
            dma_cnt    <= '0;
            parity     <= 1'b0;
            align_left <= 1'b0;
        end else begin
            parity   <= ~parity;
            // gnt and mem_we still describe the access that completes this edge
            rd_valid <= gnt & {NUM_REQ{~mem_we}};

            gnt[REQ_FET] <= fet_win;
            gnt[REQ_EXE] <= exe_win;
            gnt[REQ_DMA] <= dma_win;

            mem_we <= 1'b0;
            if (fet_win) begin
                mem_addr <= fet_addr;
            end else if (exe_win) begin
                mem_addr  <= exe_addr;
                mem_wdata <= exe_wdata;
                mem_we    <= exe_we;
            end else if (dma_win) begin
                mem_addr  <= dma_addr;
                mem_wdata <= dma_wdata;
                mem_we    <= dma_we;
                if (dma_we) begin
                    dma_cnt <= dma_cnt + CNT_W'(1);
                end
            end

            case (state)
                ARB_IDLE, ARB_CPU: begin
                    if (dma_req) begin
                        state      <= ARB_DMA_ALIGN;
                        cpu_halt   <= 1'b1;
                        // An odd entry cycle costs one extra dummy cycle
                        align_left <= parity;
                    end else begin
                        state <= (fet_win || exe_win) ? ARB_CPU : ARB_IDLE;
                    end
                end
                ARB_DMA_ALIGN: begin
                    if (align_left) begin
                        align_left <= 1'b0;
                    end else begin
                        state <= ARB_DMA_RUN;
                    end
                end
                ARB_DMA_RUN: begin
                    // A dropped dma_req simply stays here with no grant
                    if (dma_cnt == CNT_W'(DMA_LEN)) begin
                        state    <= ARB_IDLE;
                        cpu_halt <= 1'b0;
                        dma_cnt  <= '0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
